// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   state_e : arbiter FSM states
//   grant_e : which requester was granted most recently
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-state watchdog for one memory command.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   clr_i        : force count to zero
//   load_i       : start a new window of TIMEOUT busy cycles
//   en_i         : count one busy cycle
//   expired_o    : current busy cycle is the last one allowed
module mem_arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT + 1);
    // The first busy cycle already sees TIMEOUT-1, so the count reaches zero
    // on exactly the TIMEOUT-th cycle without a ready.
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = LOAD_VAL;
        else if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
//   if_*      : fetch requester (level request, instr_o + if_valid_o pulse)
//   dm_*      : data requester (read/write, dm_rdata_o + dm_valid_o pulse)
//   mem_*     : registered memory command, mem_ready_i completes it
//   stall_o   : pipeline freeze while any request is unserved
//   err_o     : sticky timeout flag
//   i/d_count : completed fetch / data transaction counters (wrap)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              if_valid_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              err_o,
    output logic [31:0]       i_count_o,
    output logic [31:0]       d_count_o
);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              err_q, err_d;
    logic [31:0]       i_count_q, i_count_d;
    logic [31:0]       d_count_q, d_count_d;

    logic if_elig, dm_elig, grant_fetch, grant_data;
    logic tmr_clr, tmr_load, tmr_en, tmr_expired;
    logic done;
    logic [DATA_W-1:0] ret_data;

    // A requester whose valid is high this cycle is still presenting the
    // request it just had served; it must not be re-granted on that cycle.
    assign if_elig = if_req_i & ~if_valid_q;
    assign dm_elig = (dm_read_i | dm_write_i) & ~dm_valid_q;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmr_clr),
        .load_i    (tmr_load),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        instr_d      = instr_q;
        dm_rdata_d   = dm_rdata_q;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        err_d        = err_q;
        i_count_d    = i_count_q;
        d_count_d    = d_count_q;
        tmr_clr      = 1'b0;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        grant_fetch  = 1'b0;
        grant_data   = 1'b0;
        done         = 1'b0;
        // A timed-out command returns zero instead of bus garbage.
        ret_data     = mem_ready_i ? mem_rdata_i : '0;

        case (state_q)
            IDLE: begin
                // On a tie the requester that did not go last wins.
                grant_fetch = if_elig & (~dm_elig | (last_grant_q == GRANT_DATA));
                grant_data  = dm_elig & (~if_elig | (last_grant_q == GRANT_FETCH));
                if (grant_fetch) begin
                    state_d      = I_BUSY;
                    last_grant_d = GRANT_FETCH;
                    mem_addr_d   = if_addr_i;
                    mem_read_d   = 1'b1;
                    mem_write_d  = 1'b0;
                    tmr_load     = 1'b1;
                end else if (grant_data) begin
                    state_d      = D_BUSY;
                    last_grant_d = GRANT_DATA;
                    mem_addr_d   = dm_addr_i;
                    mem_wdata_d  = dm_wdata_i;
                    // Read and write together is serviced as a write.
                    mem_read_d   = ~dm_write_i;
                    mem_write_d  = dm_write_i;
                    tmr_load     = 1'b1;
                end
            end
            I_BUSY, D_BUSY: begin
                tmr_en = 1'b1;
                done   = mem_ready_i | tmr_expired;
                if (done) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    tmr_clr     = 1'b1;
                    if (!mem_ready_i)
                        err_d = 1'b1;
                    if (state_q == I_BUSY) begin
                        instr_d    = ret_data;
                        if_valid_d = 1'b1;
                        i_count_d  = i_count_q + 32'd1;
                    end else begin
                        if (!mem_write_q)
                            dm_rdata_d = ret_data;
                        dm_valid_d = 1'b1;
                        d_count_d  = d_count_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_FETCH;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            instr_q      <= '0;
            dm_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            i_count_q    <= '0;
            d_count_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            instr_q      <= instr_d;
            dm_rdata_q   <= dm_rdata_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
            err_q        <= err_d;
            i_count_q    <= i_count_d;
            d_count_q    <= d_count_d;
        end
    end

    assign instr_o     = instr_q;
    assign if_valid_o  = if_valid_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_valid_o  = dm_valid_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign err_o       = err_q;
    assign i_count_o   = i_count_q;
    assign d_count_o   = d_count_q;
    assign stall_o     = (if_req_i & ~if_valid_q) | ((dm_read_i | dm_write_i) & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter with a behavioural memory.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, dm_read_i, dm_write_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
    logic [31:0] instr_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        if_valid_o, dm_valid_o, stall_o, mem_read_o, mem_write_o, mem_ready_i, err_o;
    logic [31:0] i_count_o, d_count_o;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .instr_o(instr_o), .if_valid_o(if_valid_o),
        .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
        .stall_o(stall_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i), .err_o(err_o), .i_count_o(i_count_o), .d_count_o(d_count_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference state derived from the behavioural rules.
    logic [31:0] exp_instr, exp_dm_rdata, exp_i, exp_d;
    logic        exp_err;

    // Behavioural memory: lat_cfg = command cycle on which ready is given,
    // 0 = never ready. cmd_len records the length of the last completed command.
    logic [31:0] mem [logic [31:0]];
    int          lat_cfg = 1;
    int          cyc     = 0;
    int          cmd_len = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk_i) begin
        #2;
        if (mem_read_o || mem_write_o) begin
            cyc = cyc + 1;
            if (lat_cfg != 0 && cyc == lat_cfg) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = mem_read_o ? mem_rd(mem_addr_o) : $urandom;
                if (mem_write_o) mem[mem_addr_o] = mem_wdata_o;
                cmd_len = cyc;
            end else begin
                mem_ready_i = 1'b0;
                mem_rdata_i = $urandom;
            end
        end else begin
            cyc = 0;
            // Stray ready pulses while idle must be ignored by the arbiter.
            mem_ready_i = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction from a single requester; entered just after a posedge.
    task automatic xact(input bit f, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input int lat);
        int n;
        int explat;
        bit tmo, exp_wr, got;
        logic [31:0] rv;
        tmo    = (lat == 0) || (lat > TIMEOUT);
        explat = tmo ? TIMEOUT + 1 : lat + 1;
        exp_wr = !f && wr;
        rv     = mem_rd(a);
        lat_cfg = lat;
        if (f) begin
            if_req_i = 1'b1; if_addr_i = a;
        end else begin
            dm_read_i = rd; dm_write_i = wr; dm_addr_i = a; dm_wdata_i = wd;
        end
        n = 0;
        got = 0;
        forever begin
            @(negedge clk_i);
            if (n == 0) begin
                chk("stall_req", {31'd0, stall_o}, 32'd1);
                chk("idle_no_cmd", {31'd0, mem_read_o | mem_write_o}, 32'd0);
            end
            if ((f ? if_valid_o : dm_valid_o) === 1'b1) begin
                got = 1;
                break;
            end
            if (n >= 1) begin
                chk("cmd_read", {31'd0, mem_read_o}, {31'd0, !exp_wr});
                chk("cmd_write", {31'd0, mem_write_o}, {31'd0, exp_wr});
                chk("cmd_addr", mem_addr_o, a);
                if (exp_wr) chk("cmd_wdata", mem_wdata_o, wd);
            end
            if (n > TIMEOUT + 4) break;
            @(posedge clk_i); #1;
            n++;
        end
        chk("valid_seen", {31'd0, got}, 32'd1);
        chk("latency", n, explat);
        if (f) begin
            exp_instr = tmo ? 32'd0 : rv;
            exp_i++;
        end else begin
            if (!exp_wr) exp_dm_rdata = tmo ? 32'd0 : rv;
            exp_d++;
        end
        if (tmo) exp_err = 1'b1;
        chk("other_valid", {31'd0, f ? dm_valid_o : if_valid_o}, 32'd0);
        chk("stall_done", {31'd0, stall_o}, 32'd0);
        if (f) chk("instr", instr_o, exp_instr);
        chk("dm_rdata", dm_rdata_o, exp_dm_rdata);
        chk("i_count", i_count_o, exp_i);
        chk("d_count", d_count_o, exp_d);
        chk("err", {31'd0, err_o}, {31'd0, exp_err});
        @(posedge clk_i); #1;
        if_req_i = 1'b0; dm_read_i = 1'b0; dm_write_i = 1'b0;
        @(negedge clk_i);
        chk("valid_pulse_1cyc", {30'd0, if_valid_o, dm_valid_o}, 32'd0);
        @(posedge clk_i); #1;
    endtask

    // Fetch and data read raised together: data must win, then fetch.
    task automatic pair(input int ld, input int lf);
        int n, dc, ic;
        logic [31:0] ad, af;
        ad = 32'($urandom_range(64, 127)) << 2;
        af = 32'($urandom_range(128, 191)) << 2;
        lat_cfg = ld;
        if_req_i = 1'b1; if_addr_i = af;
        dm_read_i = 1'b1; dm_addr_i = ad;
        n = 0; dc = -1; ic = -1;
        while (n < 40 && ic < 0) begin
            @(negedge clk_i);
            if (dm_valid_o === 1'b1 && dc < 0) begin
                dc = n;
                chk("pair_dm_rdata", dm_rdata_o, mem_rd(ad));
                lat_cfg = lf;
            end
            if (if_valid_o === 1'b1) begin
                ic = n;
                chk("pair_instr", instr_o, mem_rd(af));
            end
            @(posedge clk_i); #1;
            if (dc == n) dm_read_i = 1'b0;
            if (ic == n) if_req_i = 1'b0;
            n++;
        end
        if_req_i = 1'b0; dm_read_i = 1'b0;
        chk("pair_data_cycle", dc, ld + 1);
        chk("pair_fetch_cycle", ic, ld + lf + 2);
        exp_instr = mem_rd(af); exp_dm_rdata = mem_rd(ad);
        exp_i++; exp_d++;
        @(negedge clk_i);
        chk("pair_i_count", i_count_o, exp_i);
        chk("pair_d_count", d_count_o, exp_d);
        @(posedge clk_i); #1;
    endtask

    initial begin
        int kind, lat;
        logic [31:0] a, wd, ra;

        rst_i = 1'b0;
        if_req_i = 0; dm_read_i = 0; dm_write_i = 0;
        if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
        mem_ready_i = 0; mem_rdata_i = 0;
        exp_instr = 0; exp_dm_rdata = 0; exp_i = 0; exp_d = 0; exp_err = 0;
        mem[32'h0000_0004] = 32'h2001_0005;

        #12;
        chk("rst_mem_read", {31'd0, mem_read_o}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write_o}, 32'd0);
        chk("rst_valids", {30'd0, if_valid_o, dm_valid_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_i_count", i_count_o, 32'd0);
        chk("rst_d_count", d_count_o, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_dm_rdata", dm_rdata_o, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        #11 rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Zero-wait fetch of the documented instruction word.
        xact(1, 0, 0, 32'h0000_0004, 32'd0, 1);

        // Two tie rounds: data first each time since grants alternate.
        pair($urandom_range(1, 3), $urandom_range(1, 3));
        pair($urandom_range(1, 3), $urandom_range(1, 3));

        // Write with 3-cycle memory, then read it back.
        xact(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 3);
        chk("write_cmd_len", cmd_len, 32'd3);
        xact(0, 1, 0, 32'h0000_0010, 32'd0, 1);
        chk("write_readback", dm_rdata_o, 32'hDEAD_BEEF);

        // Random single-requester traffic.
        for (int k = 0; k < 8; k++) begin
            kind = $urandom_range(0, 2);
            lat  = $urandom_range(1, 5);
            a    = 32'($urandom_range(0, 31)) << 2;
            wd   = $urandom;
            xact(kind == 0, kind == 1, kind == 2, a, wd, lat);
        end

        // Read and write together behave as a write.
        wd = $urandom;
        xact(0, 1, 1, 32'h0000_0020, wd, 2);
        chk("rw_stored", mem_rd(32'h0000_0020), wd);

        // Memory never ready: timeout, sticky error, next fetch still works.
        xact(0, 1, 0, 32'h0000_0044, 32'd0, 0);
        xact(1, 0, 0, 32'h0000_0048, 32'd0, 2);

        // Asynchronous reset in the middle of a data command.
        lat_cfg = 0;
        dm_read_i = 1'b1; dm_addr_i = 32'h0000_0050;
        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        chk("arst_mem_read", {31'd0, mem_read_o}, 32'd0);
        chk("arst_mem_write", {31'd0, mem_write_o}, 32'd0);
        chk("arst_valids", {30'd0, if_valid_o, dm_valid_o}, 32'd0);
        chk("arst_err", {31'd0, err_o}, 32'd0);
        chk("arst_i_count", i_count_o, 32'd0);
        chk("arst_d_count", d_count_o, 32'd0);
        ra = 32'h0000_0060;
        dm_read_i = 1'b0; if_req_i = 1'b1; if_addr_i = ra; lat_cfg = 2;
        @(posedge clk_i);
        @(negedge clk_i); #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("post_rst_fetch_read", {31'd0, mem_read_o}, 32'd1);
        chk("post_rst_fetch_addr", mem_addr_o, ra);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("post_rst_hold", {31'd0, mem_read_o}, 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("post_rst_valid", {31'd0, if_valid_o}, 32'd1);
        chk("post_rst_instr", instr_o, mem_rd(ra));
        chk("post_rst_i_count", i_count_o, 32'd1);
        chk("post_rst_err", {31'd0, err_o}, 32'd0);
        @(posedge clk_i); #1;
        if_req_i = 1'b0;
        repeat (2) @(posedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipelined CPU's instruction fetch (IF) and data access (MEM) stages.
- Serialises their requests, drives the memory command/handshake and returns read data with one-cycle valid pulses.
- Asserts a pipeline stall while any request is outstanding.
- Counts completed fetch and data transactions so bench traces can be cross-checked.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- TIMEOUT, 64, cycles to wait for mem_ready_i before aborting; minimum 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request (level)
- if_addr_i  in  ADDR_W  fetch address
- instr_o  out  DATA_W  fetched instruction
- if_valid_o  out  1  fetch complete pulse
- dm_read_i  in  1  data read request
- dm_write_i  in  1  data write request
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data
- dm_valid_o  out  1  data complete pulse
- stall_o  out  1  freeze pipeline
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_read_o  out  1  memory read command
- mem_write_o  out  1  memory write command
- mem_rdata_i  in  DATA_W  memory read data
- mem_ready_i  in  1  memory completes command this cycle
- err_o  out  1  sticky timeout flag
- i_count_o  out  32  completed fetches
- d_count_o  out  32  completed data accesses

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE. All outputs 0. last_grant = FETCH, so data wins the first tie. A transaction in flight is dropped and memory commands deassert immediately.
- States:
  - IDLE: no transaction.
  - I_BUSY: fetch command on memory.
  - D_BUSY: data command on memory.
- Requester contract:
  - Request and address/wdata stay stable until the matching valid pulse.
  - The requester may change them at the edge where valid is high.
- IDLE issue rule:
  - Eligible requesters are those requesting whose own valid_o is not high this cycle.
  - If only one is eligible, grant it.
  - If both are eligible, grant the one not equal to last_grant.
  - The granted state is entered at the next edge, and last_grant updates to it.
- BUSY states:
  - mem_addr_o, mem_read_o/mem_write_o and mem_wdata_o are registered and stable for the whole state.
  - mem_ready_i may be high in the first BUSY cycle.
  - At the edge with mem_ready_i high: return to IDLE, capture mem_rdata_i into instr_o (I_BUSY) or dm_rdata_o (D_BUSY read), pulse the matching valid for exactly 1 cycle, and increment the matching counter.
- Latency: request seen in IDLE at cycle 0, command on cycles 1..N, valid on cycle N+1. Zero-wait memory gives 2 cycles.
- Writes: dm_valid_o pulses on completion; dm_rdata_o holds its previous value.
- dm_read_i and dm_write_i both high: treated as a write only.
- Timeout:
  - Counter clears on entering BUSY.
  - If TIMEOUT cycles pass with no mem_ready_i: go to IDLE, set err_o (sticky until reset), pulse the matching valid with read data 0, and still increment the counter.
- stall_o (combinational) = (if_req_i & ~if_valid_o) | ((dm_read_i | dm_write_i) & ~dm_valid_o).
- Counters: wrap modulo 2^32.
- mem_ready_i while IDLE: ignored.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, I_BUSY, D_BUSY}
  - grant enum {GRANT_FETCH, GRANT_DATA}
  - default ADDR_W/DATA_W constants
- One sub-module, mem_arb_timer: loadable down-counter with clear/enable and an expired flag, width $clog2(TIMEOUT+1).

Test Plan:
- Fetch only, zero-wait memory, if_addr 0x0000_0004, rdata 0x2001_0005:
  - mem_read_o high on cycle 1; instr_o = 0x2001_0005 with if_valid_o on cycle 2.
  - stall_o high on cycles 0–1 and low on cycle 2; i_count_o = 1.
- Simultaneous fetch and data read after reset:
  - Data served first, then fetch.
  - Next simultaneous pair: data then fetch again, because last_grant alternates.
  - The bench sees no back-to-back same-requester grant while both are pending.
- Data write, addr 0x0000_0010, wdata 0xDEAD_BEEF, memory ready after 3 cycles:
  - mem_write_o held 3 cycles with stable addr/data.
  - dm_valid_o pulses once; dm_rdata_o unchanged; d_count_o = 1.
- mem_ready_i never asserted, TIMEOUT=64:
  - Abort after 64 cycles; err_o = 1 and sticky.
  - dm_rdata_o = 0 with dm_valid_o pulse.
  - A following fetch completes normally.
- rst_i driven low mid-D_BUSY (not on a clock edge):
  - mem_read_o/mem_write_o, valids, err_o and counters go to 0 immediately.
  - After release, a pending fetch is granted first.
- dm_read_i and dm_write_i both high:
  - Only mem_write_o asserted; mem_read_o stays 0.
